// File: rtl/tmr_pkg.sv
// Shared types for the triplicated scrub register: scrub FSM states and
// fault-injection target encodings.
package tmr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    CORRECT = 2'd2
  } scrub_state_e;

  typedef enum logic [1:0] {
    INJ_A    = 2'd0,
    INJ_B    = 2'd1,
    INJ_C    = 2'd2,
    INJ_NONE = 2'd3
  } inj_sel_e;

  localparam int NUM_COPIES = 3;

endpackage : tmr_pkg

// File: rtl/voter.sv
// Bitwise 2-of-3 majority voter; every output bit is defined for any input.
module voter #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] y
);

  assign y = (a & b) | (b & c) | (a & c);

endmodule : voter

// File: rtl/tmr_scrub_reg.sv
// Triplicated storage register with periodic majority scrub, saturating upset
// counter, sticky multi-upset flag and a single-copy fault-injection port.
module tmr_scrub_reg
  import tmr_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int SCRUB_PERIOD = 16,
  parameter int ERR_CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 inj_en,
  input  logic [1:0]           inj_sel,
  input  logic [WIDTH-1:0]     inj_mask,
  output logic [WIDTH-1:0]     copy_a,
  output logic [WIDTH-1:0]     copy_b,
  output logic [WIDTH-1:0]     copy_c,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 mismatch,
  output logic                 scrub_busy,
  output logic                 scrub_done,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 multi_err
);

  localparam int                TIMER_W    = $clog2(SCRUB_PERIOD);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SCRUB_PERIOD - 1);

  scrub_state_e         state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [WIDTH-1:0]     copy_q [NUM_COPIES];
  logic [WIDTH-1:0]     copy_d [NUM_COPIES];
  logic                 found_q, found_d;
  logic                 multi_q, multi_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 multi_err_q, multi_err_d;

  logic                  wr_fire;
  logic                  all_differ;
  logic [NUM_COPIES-1:0] inj_hit;

  voter #(.WIDTH(WIDTH)) u_voter (
    .a (copy_q[0]),
    .b (copy_q[1]),
    .c (copy_q[2]),
    .y (rd_data)
  );

  assign mismatch   = (copy_q[0] != copy_q[1]) || (copy_q[1] != copy_q[2]);
  assign all_differ = (copy_q[0] != copy_q[1]) && (copy_q[1] != copy_q[2]) &&
                      (copy_q[0] != copy_q[2]);

  // Handshake comes purely from registered state, so wr_valid never loops back.
  assign wr_ready = (state_q == IDLE);
  assign wr_fire  = wr_valid && wr_ready;

  assign inj_hit[0] = inj_en && (inj_sel == INJ_A);
  assign inj_hit[1] = inj_en && (inj_sel == INJ_B);
  assign inj_hit[2] = inj_en && (inj_sel == INJ_C);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    timer_d     = timer_q;
    found_d     = found_q;
    multi_d     = multi_q;
    err_cnt_d   = err_cnt_q;
    multi_err_d = multi_err_q;

    unique case (state_q)
      IDLE: begin
        if (timer_q == TIMER_LAST) begin
          state_d = COMPARE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      COMPARE: begin
        found_d = mismatch;
        multi_d = all_differ;
        state_d = CORRECT;
      end
      CORRECT: begin
        state_d = IDLE;
        if (found_q && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
        if (multi_q) multi_err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Per-copy priority: scrub rewrite, then accepted write, then injection.
    for (int i = 0; i < NUM_COPIES; i++) begin
      if (state_q == CORRECT)  copy_d[i] = rd_data;
      else if (wr_fire)        copy_d[i] = wr_data;
      else if (inj_hit[i])     copy_d[i] = copy_q[i] ^ inj_mask;
      else                     copy_d[i] = copy_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      found_q     <= 1'b0;
      multi_q     <= 1'b0;
      err_cnt_q   <= '0;
      multi_err_q <= 1'b0;
      // NOTE: the copies are three plain flops, not a RAM, so they take the async reset too.
      for (int i = 0; i < NUM_COPIES; i++) copy_q[i] <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      state_q     <= state_d;
      timer_q     <= timer_d;
      found_q     <= found_d;
      multi_q     <= multi_d;
      err_cnt_q   <= err_cnt_d;
      multi_err_q <= multi_err_d;
      for (int i = 0; i < NUM_COPIES; i++) copy_q[i] <= copy_d[i];
    end
  end

  assign copy_a     = copy_q[0];
  assign copy_b     = copy_q[1];
  assign copy_c     = copy_q[2];
  assign scrub_busy = (state_q != IDLE);
  assign scrub_done = (state_q == CORRECT);
  assign err_cnt    = err_cnt_q;
  assign multi_err  = multi_err_q;

endmodule : tmr_scrub_reg

// File: tb/tb_tmr_scrub_reg.sv
// Self-checking bench for tmr_scrub_reg: directed scenarios with literal
// expectations, then randomized traffic against a schedule-based model.
module tb_tmr_scrub_reg;

  localparam int W       = 8;
  localparam int SP      = 16;
  localparam int EW      = 2;
  localparam int ERR_MAX = (1 << EW) - 1;
  localparam int PERIOD  = SP + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [W-1:0]  wr_data = '0;
  logic          inj_en = 1'b0;
  logic [1:0]    inj_sel = 2'd3;
  logic [W-1:0]  inj_mask = '0;
  logic [W-1:0]  copy_a, copy_b, copy_c, rd_data;
  logic          mismatch, scrub_busy, scrub_done, multi_err;
  logic [EW-1:0] err_cnt;

  int vectors = 0;
  int miscompares = 0;
  bit cmp_en = 1'b0;

  tmr_scrub_reg #(.WIDTH(W), .SCRUB_PERIOD(SP), .ERR_CNT_W(EW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .inj_en     (inj_en),
    .inj_sel    (inj_sel),
    .inj_mask   (inj_mask),
    .copy_a     (copy_a),
    .copy_b     (copy_b),
    .copy_c     (copy_c),
    .rd_data    (rd_data),
    .mismatch   (mismatch),
    .scrub_busy (scrub_busy),
    .scrub_done (scrub_done),
    .err_cnt    (err_cnt),
    .multi_err  (multi_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Majority by counting ones per bit position.
  function automatic logic [W-1:0] vote3(input logic [W-1:0] a, b, c);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      int ones;
      ones = int'(a[i]) + int'(b[i]) + int'(c[i]);
      r[i] = (ones >= 2);
    end
    return r;
  endfunction

  // Model: position within the fixed SP+2 schedule since reset; SP = compare, SP+1 = correct.
  logic [W-1:0] m_copy [3];
  int m_pos, m_err;
  bit m_found, m_multi, m_multi_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) m_copy[i] <= '0;
      m_pos <= 0; m_err <= 0; m_found <= 0; m_multi <= 0; m_multi_err <= 0;
    end else begin
      if (m_pos == SP) begin
        m_found <= !(m_copy[0] == m_copy[1] && m_copy[1] == m_copy[2]);
        m_multi <= (m_copy[0] != m_copy[1]) && (m_copy[1] != m_copy[2]) && (m_copy[0] != m_copy[2]);
      end
      if (m_pos == SP + 1) begin
        for (int i = 0; i < 3; i++) m_copy[i] <= vote3(m_copy[0], m_copy[1], m_copy[2]);
        if (m_found) m_err <= (m_err >= ERR_MAX) ? ERR_MAX : m_err + 1;
        if (m_multi) m_multi_err <= 1'b1;
      end else begin
        for (int i = 0; i < 3; i++) begin
          if (wr_valid && m_pos < SP)              m_copy[i] <= wr_data;
          else if (inj_en && int'(inj_sel) == i)   m_copy[i] <= m_copy[i] ^ inj_mask;
        end
      end
      m_pos <= (m_pos + 1) % PERIOD;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("copy_a",     copy_a,     m_copy[0]);
      check("copy_b",     copy_b,     m_copy[1]);
      check("copy_c",     copy_c,     m_copy[2]);
      check("rd_data",    rd_data,    vote3(m_copy[0], m_copy[1], m_copy[2]));
      check("mismatch",   mismatch,   32'(m_copy[0] != m_copy[1] || m_copy[1] != m_copy[2]));
      check("scrub_busy", scrub_busy, 32'(m_pos >= SP));
      check("scrub_done", scrub_done, 32'(m_pos == SP + 1));
      check("wr_ready",   wr_ready,   32'(m_pos < SP));
      check("err_cnt",    err_cnt,    m_err);
      check("multi_err",  multi_err,  32'(m_multi_err));
    end
  end

  task automatic cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_valid = 1'b0;
    inj_en   = 1'b0;
    inj_sel  = 2'd3;
    inj_mask = '0;
  endtask

  task automatic wait_pos(input int p, output int dones);
    dones = 0;
    for (int i = 0; i < PERIOD + 2 && m_pos != p; i++) begin
      cycle();
      dones += int'(scrub_done);
    end
    check("wait_pos", m_pos, p);
  endtask

  task automatic inject(input logic [1:0] sel, input logic [W-1:0] mask);
    inj_en = 1'b1; inj_sel = sel; inj_mask = mask;
    cycle();
    idle_inputs();
  endtask

  task automatic write(input logic [W-1:0] d);
    wr_valid = 1'b1; wr_data = d;
    cycle();
    idle_inputs();
  endtask

  initial begin
    int dones, lows;
    bit acc;

    repeat (3) cycle();
    rst_n = 1'b1;
    cmp_en = 1'b1;
    check("rst copy_a", copy_a, 8'h00);
    check("rst rd_data", rd_data, 8'h00);
    check("rst wr_ready", wr_ready, 1'b1);
    check("rst busy", scrub_busy, 1'b0);
    check("rst err_cnt", err_cnt, 0);

    // Reset and write
    write(8'hA5);
    check("wr copy_a", copy_a, 8'hA5);
    check("wr copy_c", copy_c, 8'hA5);
    check("wr rd_data", rd_data, 8'hA5);
    wait_pos(0, dones);
    check("clean mismatch", mismatch, 1'b0);
    check("clean err_cnt", err_cnt, 0);
    check("clean dones", dones, 1);

    // Single upset corrected
    inject(2'd1, 8'h0F);
    check("upset copy_b", copy_b, 8'hAA);
    check("upset rd_data", rd_data, 8'hA5);
    check("upset mismatch", mismatch, 1'b1);
    wait_pos(0, dones);
    check("fixed copy_b", copy_b, 8'hA5);
    check("fixed err_cnt", err_cnt, 1);
    check("fixed dones", dones, 1);

    // Multi-copy upset
    write(8'h00);
    inject(2'd0, 8'h11);
    inject(2'd1, 8'h22);
    check("multi copy_a", copy_a, 8'h11);
    check("multi copy_b", copy_b, 8'h22);
    check("multi rd_data", rd_data, 8'h00);
    wait_pos(0, dones);
    check("multi_err", multi_err, 1'b1);
    check("multi fixed copy_a", copy_a, 8'h00);
    check("multi err_cnt", err_cnt, 2);

    // Write on terminal timer cycle hides an earlier upset from the scrub
    inject(2'd2, 8'h01);
    wait_pos(SP - 1, dones);
    write(8'h5A);
    check("term busy", scrub_busy, 1'b1);
    wait_pos(0, dones);
    check("term copy_c", copy_c, 8'h5A);
    check("term err_cnt", err_cnt, 2);

    // Handshake under scrub
    wait_pos(SP, dones);
    wr_valid = 1'b1; wr_data = 8'h3C; lows = 0; acc = 1'b0;
    for (int i = 0; i < PERIOD && !acc; i++) begin
      if (wr_ready) acc = 1'b1;
      else lows++;
      cycle();
    end
    idle_inputs();
    check("hs low cycles", lows, 2);
    check("hs copy_b", copy_b, 8'h3C);
    check("hs landing pos", m_pos, 1);

    // Collision: write beats injection
    wr_valid = 1'b1; wr_data = 8'h77; inj_en = 1'b1; inj_sel = 2'd2; inj_mask = 8'hFF;
    cycle();
    idle_inputs();
    check("coll copy_c", copy_c, 8'h77);
    // Injection in COMPARE lands but is not counted; injection in CORRECT is lost
    wait_pos(SP, dones);
    inject(2'd0, 8'h80);
    check("cmp inj copy_a", copy_a, 8'hF7);
    inject(2'd1, 8'hFF);
    check("corr inj copy_a", copy_a, 8'h77);
    check("corr inj copy_b", copy_b, 8'h77);
    check("corr inj err_cnt", err_cnt, 2);

    // Saturation
    for (int k = 0; k < 4; k++) begin
      inject(2'(k % 3), 8'h01);
      wait_pos(0, dones);
    end
    check("sat err_cnt", err_cnt, 3);

    // Async reset mid-COMPARE
    inject(2'd0, 8'h0F);
    wait_pos(SP, dones);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset busy", scrub_busy, 1'b0);
    check("areset copy_a", copy_a, 8'h00);
    check("areset err_cnt", err_cnt, 0);
    check("areset multi_err", multi_err, 1'b0);
    check("areset wr_ready", wr_ready, 1'b1);
    check("areset done", scrub_done, 1'b0);
    cycle();
    rst_n = 1'b1;

    // Randomized traffic checked every cycle by the compare process
    for (int n = 0; n < 1500; n++) begin
      wr_valid = ($urandom_range(0, 3) == 0);
      wr_data  = W'($urandom);
      inj_en   = ($urandom_range(0, 4) == 0);
      inj_sel  = 2'($urandom_range(0, 3));
      inj_mask = W'($urandom_range(1, 255));
      cycle();
    end
    idle_inputs();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_tmr_scrub_reg

// File: doc/tmr_scrub_reg.md
# tmr_scrub_reg

Triplicated, self-scrubbing storage register that produces the three redundant copies consumed by the team's bitwise-majority `voter`. It accepts a single-writer value over a valid/ready handshake and holds it in three independent copies. A periodic scrub FSM rewrites all copies from the voted value and counts upsets. A fault-injection port lets benches and on-chip test logic corrupt any single copy.

## Interface
- `WIDTH`, 8: data width of each copy.
- `SCRUB_PERIOD`, 16: idle cycles between scrubs (≥ 2).
- `ERR_CNT_W`, 8: width of the saturating upset counter.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  **asynchronous, active-low reset.**
- `wr_valid`  in  1  write request.
- `wr_ready`  out  1  write can be accepted this cycle.
- `wr_data`  in  WIDTH  value to store.
- `inj_en`  in  1  apply fault injection this cycle.
- `inj_sel`  in  2  target copy: 0 = a, 1 = b, 2 = c, 3 = none.
- `inj_mask`  in  WIDTH  bits XORed into the target copy.
- `copy_a`, `copy_b`, `copy_c`  out  WIDTH  raw registered copies.
- `rd_data`  out  WIDTH  bitwise majority of the copies (combinational).
- `mismatch`  out  1  copies not all equal (combinational).
- `scrub_busy`  out  1  FSM is not in IDLE.
- `scrub_done`  out  1  one-cycle pulse in the CORRECT cycle.
- `err_cnt`  out  ERR_CNT_W  scrubs that found a mismatch; saturates.
- `multi_err`  out  1  sticky flag: a scrub saw all three copies pairwise different.

## Operation
- **Reset:**
  - All copies 0, `rd_data` 0, `mismatch` 0.
  - FSM in IDLE, timer 0.
  - `err_cnt` 0, `multi_err` 0, `scrub_done` 0, `scrub_busy` 0.
  - `wr_ready` 1 as soon as `rst_n` is released.
- **FSM states:** IDLE → COMPARE → CORRECT → IDLE.
- **IDLE:**
  - `wr_ready` = 1.
  - The timer increments each cycle.
  - At `timer == SCRUB_PERIOD-1`, go to COMPARE and clear the timer.
- **COMPARE (1 cycle):**
  - `wr_ready` = 0.
  - Latch `found = mismatch` and `multi = (a≠b)&(b≠c)&(a≠c)`.
- **CORRECT (1 cycle):**
  - `wr_ready` = 0.
  - Load `rd_data` into all three copies.
  - Pulse `scrub_done`.
  - If `found`, add 1 to `err_cnt`, saturating at all-ones.
  - If `multi`, set `multi_err`.
  - Return to IDLE.
- **Write:** on `wr_valid & wr_ready` at an edge, all three copies load `wr_data`.
- **Injection:** when `inj_en` and `inj_sel` ≠ 3, the selected copy becomes `copy ^ inj_mask` at the edge.
- **Priority per copy per edge:** reset > CORRECT load > accepted write > injection. A dropped injection is not retried.
- **Write on the terminal timer cycle:** the write is accepted and the FSM still enters COMPARE. COMPARE then sees equal copies, so `found` = 0.
- **Injection during COMPARE:** applied. It is not seen by the current scrub's latch and is overwritten in CORRECT.
- **`multi_err`:** cleared only by reset.
- **Voting:** the voter is bitwise, so `rd_data` is always defined. Double upsets in the same bit position silently produce wrong data; `multi_err` is the only indication.

## Timing
- **Write latency:** accepted at edge N; copies and `rd_data` show the new value after edge N.
- **Injection latency:** effect is visible after the same edge.
- **Scrub cycle:** SCRUB_PERIOD cycles in IDLE, then COMPARE and CORRECT (2 cycles, `scrub_busy` = 1). The repetition period is SCRUB_PERIOD+2.
- **`err_cnt` / `multi_err`:** update at the edge ending CORRECT.
- **`wr_ready`:** registered-state-derived. It never depends combinationally on `wr_valid`.
- **Reset mid-scrub:** asynchronous return to IDLE with all reset values; no partial correction is kept.

## Structure
- Shared package `tmr_pkg`: the FSM state enum (`IDLE`, `COMPARE`, `CORRECT`) and the `inj_sel` encodings (`INJ_A`, `INJ_B`, `INJ_C`, `INJ_NONE`).
- One sub-module: instantiate the existing `voter #(.WIDTH(WIDTH))` for `rd_data`; no new voter logic.
- Timer width: `$clog2(SCRUB_PERIOD)`.

## Test plan
- **Reset and write:**
  - Stimulus: release reset, then write 8'hA5.
  - Response: after that edge, copies = A5 and `rd_data` = A5; `mismatch` = 0 and `err_cnt` = 0 after the next scrub.
- **Single upset corrected:**
  - Stimulus: with A5 stored, inject `inj_sel` = 1, mask 8'h0F.
  - Response: `copy_b` = AA, `rd_data` = A5, `mismatch` = 1; after the next CORRECT, all copies = A5, `err_cnt` = 1, `scrub_done` pulses once.
- **Multi-copy upset:**
  - Stimulus: copies 00; inject a ^= 8'h11, then b ^= 8'h22.
  - Response: a = 11, b = 22, c = 00, `rd_data` = 00; the scrub sets `multi_err` = 1 and all copies = 00.
- **Handshake under scrub:**
  - Stimulus: hold `wr_valid` with 8'h3C across a scrub.
  - Response: `wr_ready` = 0 for exactly 2 cycles; the write lands on the first IDLE edge.
- **Collision priority:**
  - Stimulus: simultaneous write 8'h77 and injection on c.
  - Response: all copies = 77.
  - Stimulus: injection during CORRECT.
  - Response: the injection is lost and all copies hold the voted value.
- **Saturation and async reset:**
  - Stimulus (`ERR_CNT_W` = 2): four scrubs each preceded by an injection.
  - Response: `err_cnt` = 3.
  - Stimulus: `rst_n` low mid-COMPARE.
  - Response: all outputs return to reset values immediately.
